instr_fetch_unit: RTL

//  Upstream fetch stage of the multi-cycle MIPS core: owns the PC, fetches one 32-bit word per

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_npc_calc.sv | 34 +++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state codes, next-PC select codes and
// the default reset PC.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StExec  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    NpcSeq = 2'b00,
    NpcBr  = 2'b01,
    NpcJ   = 2'b10
  } npc_sel_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_3000;

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC resolution: jump beats taken branch beats sequential.
module instr_fetch_unit_npc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_index,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4
);

  npc_sel_e    sel;
  logic [31:0] br_off;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off   = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
    if (jump) begin
      sel = NpcJ;
    end else if (branch && zero) begin
      sel = NpcBr;
    end else begin
      sel = NpcSeq;
    end
    unique case (sel)
      NpcJ:    npc = {pc_plus4[31:28], instr_index, 2'b00};
      NpcBr:   npc = pc_plus4 + br_off;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register and IDLE/FETCH/EXEC sequencing.
// Optional alignment checking is enabled by defining IF_ALIGN_CHECK_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc, npc_eff;

  instr_fetch_unit_npc_calc u_npc_calc (
    .pc          (pc_q),
    .instr_index (instr_q[25:0]),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .npc         (npc),
    .pc_plus4    (pc_plus4)
  );

`ifdef IF_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;
  assign npc_eff   = npc;
  assign align_err = align_err_q;
`else
  assign npc_eff = npc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef IF_ALIGN_CHECK_EN
    align_err_d = align_err_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef IF_ALIGN_CHECK_EN
        // Once flagged, the unit parks here until reset.
        if (align_err_q) begin
          state_d = StIdle;
        end else if (pc_q[1:0] != 2'b00) begin
          align_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          state_d = StFetch;
        end
`else
        state_d = StFetch;
`endif
      end
      StFetch: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
`ifdef IF_ALIGN_CHECK_EN
          if (npc_eff[1:0] != 2'b00) begin
            align_err_d = 1'b1;
            state_d     = StIdle;
          end else begin
            pc_d    = npc_eff;
            state_d = StFetch;
          end
`else
          pc_d    = npc_eff;
          state_d = StFetch;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef IF_ALIGN_CHECK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = (state_q == StExec);
  assign pc          = pc_q;

endmodule
